// File: rtl/cache_engine.sv
// cache_engine: trace-driven set-associative cache model with true-LRU
// replacement, write-back/write-allocate, an L2 request port and on-block
// statistics counters.
// Optional build macro STATS_SAT_EN: counters saturate instead of wrapping.
module cache_engine #(
  parameter int SETS        = 16384,
  parameter int WAYS        = 8,
  parameter int LINE_BYTES  = 64,
  parameter int ALLOW_WRITE = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       n,
  input  logic [31:0]      add_in,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic             l2_req_valid,
  output logic             l2_req_wr,
  output logic [31:0]      l2_add,
  input  logic             l2_req_ready,
  output logic [CNT_W-1:0] reads,
  output logic [CNT_W-1:0] writes,
  output logic [CNT_W-1:0] hits,
  output logic [CNT_W-1:0] misses,
  output logic             print
);
  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(SETS);
  localparam int AW    = $clog2(WAYS);
  localparam int TAG_W = 32 - OFF - IDX;
  localparam int ENT   = SETS * WAYS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_FLUSH  = 3'd5;

  localparam logic [3:0] C_READ  = 4'd0;
  localparam logic [3:0] C_WRITE = 4'd1;
  localparam logic [3:0] C_FETCH = 4'd2;
  localparam logic [3:0] C_INV   = 4'd3;
  localparam logic [3:0] C_CLEAR = 4'd8;
  localparam logic [3:0] C_PRINT = 4'd9;

  // Counter increment: wraps by default, saturates with STATS_SAT_EN.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef STATS_SAT_EN
    if (&c) cnt_inc = c;
    else    cnt_inc = c + CNT_W'(1);
`else
    cnt_inc = c + CNT_W'(1);
`endif
  endfunction

  // Per-way state, entry index = {set, way}
  logic             valid_q [ENT];
  logic             dirty_q [ENT];
  logic [TAG_W-1:0] tag_q   [ENT];
  logic [AW-1:0]    age_q   [ENT];

  logic [2:0]       state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [31:0]      addr_q, addr_d;
  logic [AW-1:0]    victim_q, victim_d;
  logic [IDX-1:0]   flush_q, flush_d;
  logic [CNT_W-1:0] reads_q, reads_d, writes_q, writes_d;
  logic [CNT_W-1:0] hits_q, hits_d, misses_q, misses_d;
  logic             ready_q, rsp_valid_q, rsp_hit_q, rsp_hit_d;
  logic             l2_valid_q, l2_wr_q, print_q;
  logic [31:0]      l2_add_q, l2_add_d;

  logic [IDX-1:0]   idx_s;
  logic [TAG_W-1:0] tag_s;
  logic             hit_s, inv_found_s, accept_s, is_acc_s, is_wr_s;
  logic [AW-1:0]    hit_way_s, victim_s, victim_sel_s, touch_way_s, old_age_s;
  logic             touch_en_s;
  logic [31:0]      wb_addr_s, fill_addr_s;

  assign idx_s        = addr_q[OFF+IDX-1:OFF];
  assign tag_s        = addr_q[31:OFF+IDX];
  assign accept_s     = (state_q == S_IDLE) && cmd_valid && ready_q;
  assign is_wr_s      = (cmd_q == C_WRITE) && (ALLOW_WRITE != 0);
  assign is_acc_s     = (cmd_q == C_READ) || (cmd_q == C_FETCH) || is_wr_s;
  assign victim_sel_s = (state_q == S_LOOKUP) ? victim_s : victim_q;
  assign wb_addr_s    = 32'({tag_q[{idx_s, victim_sel_s}], idx_s}) << OFF;
  assign fill_addr_s  = (addr_q >> OFF) << OFF;
  assign old_age_s    = age_q[{idx_s, touch_way_s}];

  // Tag compare and victim choice: lowest invalid way, else the oldest way.
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = '0;
    inv_found_s = 1'b0;
    victim_s    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[{idx_s, AW'(w)}] && (tag_q[{idx_s, AW'(w)}] == tag_s) && !hit_s) begin
        hit_s     = 1'b1;
        hit_way_s = AW'(w);
      end else begin
        hit_s     = hit_s;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[{idx_s, AW'(w)}] && !inv_found_s) begin
        inv_found_s = 1'b1;
        victim_s    = AW'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found_s && (age_q[{idx_s, AW'(w)}] == {AW{1'b1}})) victim_s = AW'(w);
      else                                                         victim_s = victim_s;
    end
  end

  // LRU touch on an access hit or a completed fill.
  always_comb begin
    touch_en_s  = 1'b0;
    touch_way_s = '0;
    if ((state_q == S_LOOKUP) && is_acc_s && hit_s) begin
      touch_en_s  = 1'b1;
      touch_way_s = hit_way_s;
    end else if ((state_q == S_FILL) && l2_req_ready) begin
      touch_en_s  = 1'b1;
      touch_way_s = victim_q;
    end else begin
      touch_en_s  = 1'b0;
    end
  end

  // Next-state, command capture and statistics.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    victim_d  = victim_q;
    flush_d   = flush_q;
    reads_d   = reads_q;
    writes_d  = writes_q;
    hits_d    = hits_q;
    misses_d  = misses_q;
    rsp_hit_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cmd_d  = n;
          addr_d = add_in;
          if (n == C_CLEAR) begin
            state_d  = S_FLUSH;
            flush_d  = '0;
            reads_d  = '0;
            writes_d = '0;
            hits_d   = '0;
            misses_d = '0;
          end else begin
            state_d = S_LOOKUP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        victim_d = victim_s;
        if (is_acc_s) begin
          if (is_wr_s) writes_d = cnt_inc(writes_q);
          else         reads_d  = cnt_inc(reads_q);
          if (hit_s) begin
            hits_d    = cnt_inc(hits_q);
            rsp_hit_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            misses_d = cnt_inc(misses_q);
            if (valid_q[{idx_s, victim_s}] && dirty_q[{idx_s, victim_s}]) state_d = S_WB;
            else                                                          state_d = S_FILL;
          end
        end else if (cmd_q == C_INV) begin
          rsp_hit_d = hit_s;
          state_d   = S_RESP;
        end else begin
          state_d = S_RESP;
        end
      end
      S_WB: begin
        if (l2_req_ready) state_d = S_FILL;
        else              state_d = S_WB;
      end
      S_FILL: begin
        if (l2_req_ready) state_d = S_RESP;
        else              state_d = S_FILL;
      end
      S_FLUSH: begin
        if (flush_q == {IDX{1'b1}}) state_d = S_RESP;
        else                        flush_d = flush_q + IDX'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // L2 address for the request the next state will present.
  always_comb begin
    case (state_d)
      S_WB:    l2_add_d = wb_addr_s;
      S_FILL:  l2_add_d = fill_addr_s;
      default: l2_add_d = 32'd0;
    endcase
  end

  // Control, statistics and registered outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= S_IDLE;
      cmd_q       <= 4'd0;
      addr_q      <= 32'd0;
      victim_q    <= '0;
      flush_q     <= '0;
      reads_q     <= '0;
      writes_q    <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      l2_valid_q  <= 1'b0;
      l2_wr_q     <= 1'b0;
      l2_add_q    <= 32'd0;
      print_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      victim_q    <= victim_d;
      flush_q     <= flush_d;
      reads_q     <= reads_d;
      writes_q    <= writes_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      ready_q     <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_RESP);
      rsp_hit_q   <= rsp_hit_d;
      l2_valid_q  <= (state_d == S_WB) || (state_d == S_FILL);
      l2_wr_q     <= (state_d == S_WB);
      l2_add_q    <= l2_add_d;
      print_q     <= accept_s && (n == C_PRINT);
    end
  end

  // Way state: hit/fill/invalidate updates, LRU ages and the flush walk.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int e = 0; e < ENT; e++) begin
        valid_q[e] <= 1'b0;
        dirty_q[e] <= 1'b0;
        tag_q[e]   <= '0;
        age_q[e]   <= AW'(e);
      end
    end else begin
      if (touch_en_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == touch_way_s)                  age_q[{idx_s, AW'(w)}] <= '0;
          else if (age_q[{idx_s, AW'(w)}] < old_age_s) age_q[{idx_s, AW'(w)}] <= age_q[{idx_s, AW'(w)}] + AW'(1);
        end
      end
      case (state_q)
        S_LOOKUP: begin
          if (is_acc_s && hit_s && is_wr_s) begin
            dirty_q[{idx_s, hit_way_s}] <= 1'b1;
          end else if ((cmd_q == C_INV) && hit_s) begin
            valid_q[{idx_s, hit_way_s}] <= 1'b0;
            dirty_q[{idx_s, hit_way_s}] <= 1'b0;
          end
        end
        S_FILL: begin
          if (l2_req_ready) begin
            valid_q[{idx_s, victim_q}] <= 1'b1;
            tag_q[{idx_s, victim_q}]   <= tag_s;
            dirty_q[{idx_s, victim_q}] <= is_wr_s;
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[{flush_q, AW'(w)}] <= 1'b0;
            dirty_q[{flush_q, AW'(w)}] <= 1'b0;
            age_q[{flush_q, AW'(w)}]   <= AW'(w);
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_hit      = rsp_hit_q;
  assign l2_req_valid = l2_valid_q;
  assign l2_req_wr    = l2_wr_q;
  assign l2_add       = l2_add_q;
  assign reads        = reads_q;
  assign writes       = writes_q;
  assign hits         = hits_q;
  assign misses       = misses_q;
  assign print        = print_q;
endmodule

// File: tb/tb_cache_engine.sv
// Directed bench for cache_engine: 4-set, 2-way, 64-byte data cache plus a
// small-counter instruction-cache instance for saturation/write-ignore.
module tb_cache_engine;
  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  n = 4'd0;
  logic [31:0] add_in = 32'd0;
  logic        rsp_valid, rsp_hit, l2_req_valid, l2_req_wr, print;
  logic [31:0] l2_add;
  logic        l2_req_ready = 1'b0;
  logic [31:0] reads, writes, hits, misses;

  logic        ic_valid = 1'b0;
  logic        ic_ready;
  logic [3:0]  ic_n = 4'd0;
  logic [31:0] ic_add = 32'd0;
  logic        ic_rsp_valid, ic_rsp_hit, ic_l2v, ic_l2wr, ic_print;
  logic [31:0] ic_l2add;
  logic        ic_l2rdy = 1'b1;
  logic [3:0]  ic_reads, ic_writes, ic_hits, ic_misses;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_engine #(.SETS(4), .WAYS(2), .LINE_BYTES(64), .ALLOW_WRITE(1), .CNT_W(32)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .n(n),
    .add_in(add_in), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .l2_req_valid(l2_req_valid),
    .l2_req_wr(l2_req_wr), .l2_add(l2_add), .l2_req_ready(l2_req_ready), .reads(reads),
    .writes(writes), .hits(hits), .misses(misses), .print(print));

  cache_engine #(.SETS(4), .WAYS(2), .LINE_BYTES(64), .ALLOW_WRITE(0), .CNT_W(4)) u_ic (
    .clk(clk), .clear(clear), .cmd_valid(ic_valid), .cmd_ready(ic_ready), .n(ic_n),
    .add_in(ic_add), .rsp_valid(ic_rsp_valid), .rsp_hit(ic_rsp_hit), .l2_req_valid(ic_l2v),
    .l2_req_wr(ic_l2wr), .l2_add(ic_l2add), .l2_req_ready(ic_l2rdy), .reads(ic_reads),
    .writes(ic_writes), .hits(ic_hits), .misses(ic_misses), .print(ic_print));

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    int          l2lat;
    logic        hit;
    int          nreq;
    logic [32:0] req0;
    logic [32:0] req1;
    int          lat;
    int          prn;
    logic [31:0] rd, wr, ht, ms;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [3:0] c, input logic [31:0] a, input int l2lat, input logic h,
                      input int nr, input logic [32:0] r0, input logic [32:0] r1, input int lat,
                      input int prn, input logic [31:0] rd, input logic [31:0] wr,
                      input logic [31:0] ht, input logic [31:0] ms);
    vec_t t;
    t.cmd = c; t.addr = a; t.l2lat = l2lat; t.hit = h; t.nreq = nr; t.req0 = r0; t.req1 = r1;
    t.lat = lat; t.prn = prn; t.rd = rd; t.wr = wr; t.ht = ht; t.ms = ms;
    vt.push_back(t);
  endtask

  // Issue one command, serve L2 requests with t.l2lat wait cycles, check results.
  task automatic run_vec(input int i);
    vec_t t;
    int g, cyc, wc, nreq, prc;
    logic done, hs;
    logic [32:0] rq [2];
    t = vt[i];
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    chk($sformatf("v%0d_cmd_ready", i), {32'd0, cmd_ready}, 33'd1);
    cmd_valid = 1'b1; n = t.cmd; add_in = t.addr;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1; wc = 0; nreq = 0; prc = 0; done = 1'b0; hs = 1'b0;
    rq[0] = 33'd0; rq[1] = 33'd0;
    while (!done && cyc < 200) begin
      if (print && prc == 0) prc = cyc;
      if (rsp_valid) begin
        done = 1'b1; hs = rsp_hit; l2_req_ready = 1'b0;
      end else begin
        if (l2_req_ready) l2_req_ready = 1'b0;
        else if (l2_req_valid) begin
          if (wc == 0) begin
            if (nreq < 2) rq[nreq] = {l2_req_wr, l2_add};
            nreq++;
          end else if (nreq <= 2) begin
            chk($sformatf("v%0d_l2_stable", i), {l2_req_wr, l2_add}, rq[nreq-1]);
          end
          if (wc >= t.l2lat) begin l2_req_ready = 1'b1; wc = 0; end
          else wc++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk($sformatf("v%0d_rsp_seen", i), {32'd0, done}, 33'd1);
    chk($sformatf("v%0d_hit", i), {32'd0, hs}, {32'd0, t.hit});
    chk($sformatf("v%0d_nreq", i), 33'(nreq), 33'(t.nreq));
    if (t.nreq >= 1) chk($sformatf("v%0d_req0", i), rq[0], t.req0);
    if (t.nreq >= 2) chk($sformatf("v%0d_req1", i), rq[1], t.req1);
    if (t.lat != 0) chk($sformatf("v%0d_latency", i), 33'(cyc), 33'(t.lat));
    chk($sformatf("v%0d_print", i), 33'(prc), 33'(t.prn));
    chk($sformatf("v%0d_reads", i), {1'b0, reads}, {1'b0, t.rd});
    chk($sformatf("v%0d_writes", i), {1'b0, writes}, {1'b0, t.wr});
    chk($sformatf("v%0d_hits", i), {1'b0, hits}, {1'b0, t.ht});
    chk($sformatf("v%0d_misses", i), {1'b0, misses}, {1'b0, t.ms});
    @(negedge clk);
    chk($sformatf("v%0d_rsp_pulse", i), {32'd0, rsp_valid}, 33'd0);
  endtask

  // One command on the instruction-cache instance (L2 ready tied high).
  task automatic ic_cmd(input logic [3:0] c, input logic [31:0] a, output logic h);
    int g;
    g = 0;
    while (!ic_ready && g < 100) begin @(negedge clk); g++; end
    ic_valid = 1'b1; ic_n = c; ic_add = a;
    @(negedge clk);
    ic_valid = 1'b0;
    g = 0;
    while (!ic_rsp_valid && g < 100) begin @(negedge clk); g++; end
    h = ic_rsp_hit;
    if (!ic_rsp_valid) chk("ic_rsp_timeout", {32'd0, ic_rsp_valid}, 33'd1);
    @(negedge clk);
  endtask

  localparam logic [32:0] WB0  = 33'h1_0000_0000;
  localparam logic [32:0] F000 = 33'h0_0000_0000;
  localparam logic [32:0] F040 = 33'h0_0000_0040;
  localparam logic [32:0] F100 = 33'h0_0000_0100;
  localparam logic [32:0] F200 = 33'h0_0000_0200;
  localparam logic [32:0] NONE = 33'h0;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic h;
    int g;
    //   cmd   addr      l2lat hit nreq r0    r1    lat prn rd wr ht ms
    addv(4'd0, 32'h100, 0, 1'b0, 1, F100, NONE, 3, 0, 1, 0, 0, 1);
    addv(4'd0, 32'h100, 0, 1'b1, 0, NONE, NONE, 2, 0, 2, 0, 1, 1);
    addv(4'd1, 32'h000, 0, 1'b0, 1, F000, NONE, 3, 0, 2, 1, 1, 2);
    addv(4'd1, 32'h100, 0, 1'b1, 0, NONE, NONE, 2, 0, 2, 2, 2, 2);
    addv(4'd0, 32'h200, 2, 1'b0, 2, WB0,  F200, 0, 0, 3, 2, 2, 3);
    addv(4'd0, 32'h100, 0, 1'b1, 0, NONE, NONE, 2, 0, 4, 2, 3, 3);
    addv(4'd3, 32'h100, 0, 1'b1, 0, NONE, NONE, 2, 0, 4, 2, 3, 3);
    addv(4'd0, 32'h100, 0, 1'b0, 1, F100, NONE, 3, 0, 5, 2, 3, 4);
    addv(4'd3, 32'h300, 0, 1'b0, 0, NONE, NONE, 2, 0, 5, 2, 3, 4);
    addv(4'd5, 32'h100, 0, 1'b0, 0, NONE, NONE, 2, 0, 5, 2, 3, 4);
    addv(4'd0, 32'h040, 0, 1'b0, 1, F040, NONE, 3, 0, 6, 2, 3, 5);
    addv(4'd2, 32'h040, 0, 1'b1, 0, NONE, NONE, 2, 0, 7, 2, 4, 5);
    addv(4'd9, 32'h000, 0, 1'b0, 0, NONE, NONE, 2, 1, 7, 2, 4, 5);
    addv(4'd8, 32'h000, 0, 1'b0, 0, NONE, NONE, 5, 0, 0, 0, 0, 0);
    addv(4'd0, 32'h040, 0, 1'b0, 1, F040, NONE, 3, 0, 1, 0, 0, 1);
    addv(4'd1, 32'h000, 0, 1'b0, 1, F000, NONE, 3, 0, 1, 1, 0, 2);
    addv(4'd1, 32'h100, 0, 1'b0, 1, F100, NONE, 3, 0, 1, 2, 0, 3);
    // after the clear-abort sequence
    addv(4'd0, 32'h000, 0, 1'b0, 1, F000, NONE, 3, 0, 1, 0, 0, 1);
    addv(4'd1, 32'h000, 0, 1'b1, 0, NONE, NONE, 2, 0, 1, 1, 1, 1);

    // reset state while clear is held
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {32'd0, cmd_ready}, 33'd0);
    chk("rst_rsp_valid", {32'd0, rsp_valid}, 33'd0);
    chk("rst_l2_valid", {32'd0, l2_req_valid}, 33'd0);
    chk("rst_print", {32'd0, print}, 33'd0);
    chk("rst_counters", {1'b0, reads | writes | hits | misses}, 33'd0);
    clear = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {32'd0, cmd_ready}, 33'd1);

    for (int i = 0; i < 17; i++) run_vec(i);

    // clear while a writeback is stalled on L2
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    cmd_valid = 1'b1; n = 4'd0; add_in = 32'h200;
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (!l2_req_valid && g < 20) begin @(negedge clk); g++; end
    chk("abort_wb_valid", {32'd0, l2_req_valid}, 33'd1);
    chk("abort_wb_req", {l2_req_wr, l2_add}, WB0);
    @(negedge clk);
    chk("abort_wb_hold", {l2_req_wr, l2_add}, WB0);
    clear = 1'b1;
    #1;
    chk("abort_l2_drop", {32'd0, l2_req_valid}, 33'd0);
    chk("abort_ready_low", {32'd0, cmd_ready}, 33'd0);
    @(negedge clk);
    chk("abort_counters", {1'b0, reads | writes | hits | misses}, 33'd0);
    clear = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", {32'd0, cmd_ready}, 33'd1);
    chk("abort_no_l2", {32'd0, l2_req_valid}, 33'd0);

    for (int i = 17; i < 19; i++) run_vec(i);

    // small counters on the instruction-cache instance
    for (int k = 0; k < 17; k++) ic_cmd(4'd0, 32'h100, h);
    chk("ic_last_hit", {32'd0, h}, 33'd1);
`ifdef STATS_SAT_EN
    chk("ic_reads", {29'd0, ic_reads}, 33'd15);
    chk("ic_hits", {29'd0, ic_hits}, 33'd15);
`else
    chk("ic_reads", {29'd0, ic_reads}, 33'd1);
    chk("ic_hits", {29'd0, ic_hits}, 33'd0);
`endif
    chk("ic_misses", {29'd0, ic_misses}, 33'd1);
    ic_cmd(4'd1, 32'h100, h);
    chk("ic_write_hit", {32'd0, h}, 33'd0);
    chk("ic_writes", {29'd0, ic_writes}, 33'd0);
    ic_cmd(4'd0, 32'h100, h);
    chk("ic_still_resident", {32'd0, h}, 33'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
